// File: rtl/peripheral_uart_transmitter_wb.sv
// UART serializer: pops the TX FIFO on a 16x baud tick and sends start/data/parity/stop bits.
// Optional PERIPHERAL_UART_TX_BREAK_EN forces the line low while lcr[6] (break) is set.
module peripheral_uart_transmitter_wb #(
    parameter int FIFO_WIDTH     = 8,
    parameter int FIFO_COUNTER_W = 5
) (
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic [7:0]                lcr,
    input  logic                      enable,
    input  logic [FIFO_COUNTER_W-1:0] tf_count,
    input  logic [FIFO_WIDTH-1:0]     tf_data_out,
    input  logic                      tx_reset,
    output logic                      tf_pop,
    output logic                      stx_pad_o,
    output logic [2:0]                tstate
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t                state, state_nxt;
    logic [3:0]            tick_cnt, tick_nxt;
    logic [FIFO_WIDTH-1:0] shift, shift_nxt;
    logic [2:0]            bit_cnt, bit_nxt;
    logic                  par_acc, par_nxt;
    logic                  stop_ext, stop_ext_nxt;
    logic                  pop_nxt;
    logic                  par_bit;
    logic                  ser;

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= S_IDLE;
            tick_cnt <= 4'd0;
            shift    <= '0;
            bit_cnt  <= 3'd0;
            par_acc  <= 1'b0;
            stop_ext <= 1'b0;
            tf_pop   <= 1'b0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            shift    <= shift_nxt;
            bit_cnt  <= bit_nxt;
            par_acc  <= par_nxt;
            stop_ext <= stop_ext_nxt;
            tf_pop   <= pop_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tick_nxt     = tick_cnt;
        shift_nxt    = shift;
        bit_nxt      = bit_cnt;
        par_nxt      = par_acc;
        stop_ext_nxt = stop_ext;
        pop_nxt      = 1'b0;

        if (tx_reset) begin
            state_nxt    = S_IDLE;
            tick_nxt     = 4'd0;
            stop_ext_nxt = 1'b0;
        end else if (state == S_IDLE) begin
            if (enable && (tf_count != '0)) begin
                shift_nxt = tf_data_out;
                pop_nxt   = 1'b1;
                par_nxt   = 1'b0;
                tick_nxt  = 4'd15;
                state_nxt = S_START;
            end
        end else if (enable) begin
            tick_nxt = tick_cnt - 4'd1;
            if (tick_cnt == 4'd0) begin
                tick_nxt = 4'd15;
                case (state)
                    S_START: begin
                        bit_nxt   = 3'd4 + {1'b0, lcr[1:0]};
                        state_nxt = S_DATA;
                    end
                    S_DATA: begin
                        // parity accumulates only the bits actually sent
                        par_nxt   = par_acc ^ shift[0];
                        shift_nxt = shift >> 1;
                        if (bit_cnt == 3'd0) begin
                            stop_ext_nxt = 1'b0;
                            state_nxt    = lcr[3] ? S_PARITY : S_STOP;
                        end else begin
                            bit_nxt = bit_cnt - 3'd1;
                        end
                    end
                    S_PARITY: begin
                        stop_ext_nxt = 1'b0;
                        state_nxt    = S_STOP;
                    end
                    S_STOP: begin
                        // second stop segment: 8 ticks for 5-bit words, else 16
                        if (!stop_ext && lcr[2]) begin
                            stop_ext_nxt = 1'b1;
                            tick_nxt     = (lcr[1:0] == 2'd0) ? 4'd7 : 4'd15;
                        end else begin
                            stop_ext_nxt = 1'b0;
                            state_nxt    = S_IDLE;
                        end
                    end
                    default: state_nxt = S_IDLE;
                endcase
            end
        end
    end

    assign par_bit = lcr[5] ? ~lcr[4] : (lcr[4] ? par_acc : ~par_acc);

    always_comb begin
        ser = 1'b1;
        case (state)
            S_START:  ser = 1'b0;
            S_DATA:   ser = shift[0];
            S_PARITY: ser = par_bit;
            default:  ser = 1'b1;
        endcase
    end

    logic unused_lcr;
`ifdef PERIPHERAL_UART_TX_BREAK_EN
    assign stx_pad_o  = ser & ~lcr[6];
    assign unused_lcr = lcr[7];
`else
    assign stx_pad_o  = ser;
    assign unused_lcr = ^lcr[7:6];
`endif

    assign tstate = state;

endmodule

// File: tb/tb_peripheral_uart_transmitter_wb.sv
// Randomized bench for the UART transmitter, checked per baud tick against a frame-level model.
module tb_peripheral_uart_transmitter_wb;

    logic       clk = 1'b0;
    logic       wb_rst_i;
    logic [7:0] lcr;
    logic       enable;
    logic [4:0] tf_count;
    logic [7:0] tf_data_out;
    logic       tx_reset;
    logic       tf_pop;
    logic       stx_pad_o;
    logic [2:0] tstate;

    int n_vec = 0;
    int n_err = 0;
    int pops_total = 0;
    logic exp_q[$];

`ifdef PERIPHERAL_UART_TX_BREAK_EN
    localparam logic BRK_LEVEL = 1'b0;
`else
    localparam logic BRK_LEVEL = 1'b1;
`endif

    peripheral_uart_transmitter_wb #(.FIFO_WIDTH(8), .FIFO_COUNTER_W(5)) dut (
        .clk         (clk),
        .wb_rst_i    (wb_rst_i),
        .lcr         (lcr),
        .enable      (enable),
        .tf_count    (tf_count),
        .tf_data_out (tf_data_out),
        .tx_reset    (tx_reset),
        .tf_pop      (tf_pop),
        .stx_pad_o   (stx_pad_o),
        .tstate      (tstate)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (tf_pop === 1'b1) pops_total++;

    // 16x tick: one-cycle pulse every 4 clocks
    initial begin
        enable = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            enable = 1'b1;
            @(negedge clk);
            enable = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Expected line level for each tick period after the frame start, from the framing rules.
    task automatic build_model(input logic [7:0] l, input logic [7:0] d);
        int len, stop;
        logic [7:0] mask;
        logic par;
        exp_q.delete();
        len  = 5 + int'(l[1:0]);
        mask = 8'hFF >> (8 - len);
        par  = l[5] ? ~l[4] : (l[4] ? ^(d & mask) : ~(^(d & mask)));
        stop = !l[2] ? 16 : ((len == 5) ? 24 : 32);
        repeat (16) exp_q.push_back(1'b0);
        for (int b = 0; b < len; b++) repeat (16) exp_q.push_back(d[b]);
        if (l[3]) repeat (16) exp_q.push_back(par);
        repeat (stop) exp_q.push_back(1'b1);
    endtask

    task automatic wait_en_edge();
        forever begin
            @(posedge clk);
            if (enable) break;
        end
        #1;
    endtask

    // Waits for a frame start, then checks every tick of the frame and the return to idle.
    task automatic run_frame(input logic [7:0] l, input logic [7:0] d,
                             input logic [4:0] cnt_after, input logic [7:0] d_after,
                             input int max_gap, input string name);
        int en_seen = 0;
        int p0;
        bit got = 0;
        lcr = l;
        tf_data_out = d;
        if (tf_count == 5'd0) tf_count = 5'd1;
        build_model(l, d);
        p0 = pops_total;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            if (enable) en_seen++;
            #1;
            if (tf_pop === 1'b1) begin
                got = 1;
                break;
            end
        end
        n_vec++;
        if (!got || en_seen < 1 || en_seen > max_gap) begin
            n_err++;
            $display("FAIL %s start: pop_seen=%0d enables_waited=%0d, need pop within 1..%0d enables",
                     name, got, en_seen, max_gap);
        end
        if (!got) return;
        tf_count = cnt_after;
        tf_data_out = d_after;
        n_vec++;
        if (tstate !== 3'd2) begin
            n_err++;
            $display("FAIL %s start_state: tstate=%0d want 2", name, tstate);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) wait_en_edge();
            n_vec++;
            if (stx_pad_o !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s line tick %0d: stx=%b want %b (state %0d)",
                         name, i, stx_pad_o, exp_q[i], tstate);
            end
        end
        wait_en_edge();
        n_vec++;
        if (tstate !== 3'd0 || stx_pad_o !== 1'b1) begin
            n_err++;
            $display("FAIL %s end: tstate=%0d stx=%b want 0 and 1", name, tstate, stx_pad_o);
        end
        n_vec++;
        if (pops_total - p0 != 1) begin
            n_err++;
            $display("FAIL %s pops: got %0d want 1", name, pops_total - p0);
        end
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        tx_reset = 1'b0;
        lcr = 8'h03;
        tf_count = 5'd1;
        tf_data_out = 8'h5A;
        #3;
        n_vec++;
        if (tstate !== 3'd0 || stx_pad_o !== 1'b1 || tf_pop !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: tstate=%0d stx=%b pop=%b want 0/1/0", tstate, stx_pad_o, tf_pop);
        end
        repeat (10) @(posedge clk);
        #1;
        n_vec++;
        if (tstate !== 3'd0 || pops_total != 0) begin
            n_err++;
            $display("FAIL reset_hold: tstate=%0d pops=%0d want 0/0", tstate, pops_total);
        end
        @(negedge clk);
        wb_rst_i = 1'b0;
        tf_count = 5'd0;
    endtask

    task automatic test_directed();
        run_frame(8'h03, 8'hA5, 5'd0, 8'h00, 1000, "8n1_a5");
        run_frame(8'h1A, 8'h35, 5'd0, 8'h00, 1000, "7e1_35");
        run_frame(8'h04, 8'h1F, 5'd0, 8'h00, 1000, "5b2s_1f");
        run_frame(8'h05, 8'h2C, 5'd0, 8'h00, 1000, "6b2s");
        run_frame(8'h3B, 8'hC3, 5'd0, 8'h00, 1000, "stick_par");
    endtask

    task automatic test_random();
        logic [7:0] l, d;
        for (int k = 0; k < 8; k++) begin
            l = 8'($urandom) & 8'hBF;
            d = 8'($urandom);
            run_frame(l, d, 5'd0, 8'h00, 1000, "random");
        end
    endtask

    task automatic test_back_to_back();
        tf_count = 5'd2;
        run_frame(8'h03, 8'h55, 5'd1, 8'hAA, 1000, "b2b_first");
        run_frame(8'h03, 8'hAA, 5'd0, 8'h00, 1, "b2b_second");
    endtask

    task automatic test_tx_reset();
        logic [7:0] d;
        int p0;
        d = 8'($urandom);
        tf_count = 5'd1;
        lcr = 8'h03;
        tf_data_out = d;
        p0 = pops_total;
        wait_en_edge();
        tf_count = 5'd0;
        repeat (16 * 4 + 5) wait_en_edge();
        n_vec++;
        if (tstate !== 3'd3) begin
            n_err++;
            $display("FAIL txr_pre: tstate=%0d want 3", tstate);
        end
        tx_reset = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (tstate !== 3'd0 || stx_pad_o !== 1'b1 || tf_pop !== 1'b0) begin
            n_err++;
            $display("FAIL txr_abort: tstate=%0d stx=%b pop=%b want 0/1/0", tstate, stx_pad_o, tf_pop);
        end
        tf_count = 5'd1;
        wait_en_edge();
        n_vec++;
        if (tstate !== 3'd0 || tf_pop !== 1'b0 || pops_total - p0 != 1) begin
            n_err++;
            $display("FAIL txr_priority: tstate=%0d pop=%b pops=%0d want 0/0/1",
                     tstate, tf_pop, pops_total - p0);
        end
        tx_reset = 1'b0;
        d = 8'($urandom);
        run_frame(8'h03, d, 5'd0, 8'h00, 1000, "txr_restart");
    endtask

    task automatic test_reset_mid_stop();
        bit in_stop = 0;
        lcr = 8'h43;
        tf_data_out = 8'($urandom);
        tf_count = 5'd1;
        wait_en_edge();
        tf_count = 5'd0;
        for (int c = 0; c < 400; c++) begin
            wait_en_edge();
            if (tstate === 3'd5) begin
                in_stop = 1;
                break;
            end
        end
        n_vec++;
        if (!in_stop || stx_pad_o !== BRK_LEVEL) begin
            n_err++;
            $display("FAIL brk_stop: reached_stop=%0d stx=%b want 1/%b", in_stop, stx_pad_o, BRK_LEVEL);
        end
        #2;
        wb_rst_i = 1'b1;
        #1;
        n_vec++;
        if (tstate !== 3'd0 || stx_pad_o !== BRK_LEVEL || tf_pop !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_stop: tstate=%0d stx=%b pop=%b want 0/%b/0",
                     tstate, stx_pad_o, tf_pop, BRK_LEVEL);
        end
        repeat (3) @(negedge clk);
        wb_rst_i = 1'b0;
        lcr = 8'h03;
        #1;
        n_vec++;
        if (tstate !== 3'd0 || stx_pad_o !== 1'b1) begin
            n_err++;
            $display("FAIL rst_release: tstate=%0d stx=%b want 0/1", tstate, stx_pad_o);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_tx_reset();
        test_reset_mid_stop();
        run_frame(8'h1F, 8'($urandom), 5'd0, 8'h00, 1000, "after_rst");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
